// File: rtl/pim_pkg.sv
// Shared types and constants for the PIM buffer read streamer.
package pim_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StStream,
      StDrain,
      StDone
   } stream_state_e;

   localparam int unsigned WORD_BYTES = 4;
   localparam int unsigned WORD_SHIFT = $clog2(WORD_BYTES);

   // Byte write-enables are active low on the buffer port; all ones means no write.
   localparam logic [3:0] BUF_NO_WRITE_SIZE = 4'b1111;

   typedef struct packed {
      logic        last;
      logic [31:0] data;
   } stream_entry_t;

endpackage

// File: rtl/pim_stream_fifo.sv
// Synchronous FIFO of {last, data} entries; head is read straight from the storage registers.
module pim_stream_fifo
   import pim_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            push,
   input  stream_entry_t   push_entry,
   input  logic            pop,
   output stream_entry_t   head,
   output logic [CntW-1:0] count
);

   stream_entry_t   mem_q [DEPTH];
   logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0] count_q;
   logic            do_push, do_pop;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
   endfunction

   assign do_pop  = pop && (count_q != '0);
   assign do_push = push && (count_q != CntW'(DEPTH));

   // Entry storage; contents are masked when empty so no reset is needed.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_entry;
      end
   end

   // Pointer and occupancy bookkeeping; simultaneous push and pop leave count unchanged.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CntW'(1);
            2'b01:   count_q <= count_q - CntW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   assign head  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
   assign count = count_q;

endmodule

// File: rtl/pim_buf_streamer.sv
// Read-side sequencer for pim_buffer: walks words from a base address and streams them out.
// Optional stall-cycle counter is built when PIM_STREAMER_PERF_EN is defined.
module pim_buf_streamer
   import pim_pkg::*;
#(
   parameter int unsigned MEM_ADDR_WIDTH = 15,
   parameter int unsigned LEN_WIDTH      = 16,
   parameter int unsigned FIFO_DEPTH     = 4
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_cmd_valid,
   output logic                 o_cmd_ready,
   input  logic [31:0]          i_cmd_base_addr,
   input  logic [LEN_WIDTH-1:0] i_cmd_len,
   output logic [31:0]          o_buf_addr,
   output logic                 o_buf_read,
   output logic                 o_buf_write,
   output logic [3:0]           o_buf_size,
   output logic [31:0]          o_buf_wr_data,
   input  logic [31:0]          i_buf_rd_data,
   output logic                 o_data_valid,
   output logic [31:0]          o_data,
   output logic                 o_data_last,
   input  logic                 i_data_ready,
   output logic                 o_busy,
   output logic                 o_done,
   output logic [31:0]          o_stall_cycles
);

   localparam int unsigned IdxW = MEM_ADDR_WIDTH - WORD_SHIFT;
   localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

   stream_state_e        state_q, state_d;
   logic [IdxW-1:0]      idx_q, idx_d;
   logic [LEN_WIDTH-1:0] remaining_q, remaining_d;
   logic                 inflight_q, inflight_last_q, inflight_last_d;
   logic [31:0]          addr_hold_q, issue_addr;
   logic                 issue, cmd_accept, pop;
   stream_entry_t        fifo_head;
   logic [CntW-1:0]      fifo_count;
   logic                 unused_base;

   assign unused_base = ^{i_cmd_base_addr[31:MEM_ADDR_WIDTH], i_cmd_base_addr[WORD_SHIFT-1:0]};

   assign cmd_accept = i_cmd_valid && (state_q == StIdle);
   // Reserve a FIFO slot for every read in flight so the returning word always fits.
   assign issue      = (state_q == StStream) &&
                       ((32'(fifo_count) + 32'(inflight_q)) < FIFO_DEPTH);
   assign issue_addr = 32'({idx_q, {WORD_SHIFT{1'b0}}});
   assign pop        = o_data_valid && i_data_ready;

   // Next-state, address walk and length countdown.
   always_comb begin
      state_d         = state_q;
      idx_d           = idx_q;
      remaining_d     = remaining_q;
      inflight_last_d = issue && (remaining_q == LEN_WIDTH'(1));
      case (state_q)
         StIdle: begin
            if (i_cmd_valid) begin
               idx_d       = i_cmd_base_addr[MEM_ADDR_WIDTH-1:WORD_SHIFT];
               remaining_d = i_cmd_len;
               state_d     = (i_cmd_len == '0) ? StDone : StStream;
            end
         end
         StStream: begin
            if (issue) begin
               idx_d       = idx_q + IdxW'(1);
               remaining_d = remaining_q - LEN_WIDTH'(1);
               if (remaining_q == LEN_WIDTH'(1)) state_d = StDrain;
            end
         end
         // Accepting the beat flagged last means the FIFO empties and nothing is in flight.
         StDrain: begin
            if (pop && fifo_head.last) state_d = StDone;
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // State, walk registers and the one-cycle SRAM latency tracker.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q         <= StIdle;
         idx_q           <= '0;
         remaining_q     <= '0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
         addr_hold_q     <= '0;
      end else begin
         state_q         <= state_d;
         idx_q           <= idx_d;
         remaining_q     <= remaining_d;
         inflight_q      <= issue;
         inflight_last_q <= inflight_last_d;
         if (issue) addr_hold_q <= issue_addr;
      end
   end

   pim_stream_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk        (i_clk),
      .rst        (i_rst),
      .push       (inflight_q),
      .push_entry ('{last: inflight_last_q, data: i_buf_rd_data}),
      .pop        (pop),
      .head       (fifo_head),
      .count      (fifo_count)
   );

`ifdef PIM_STREAMER_PERF_EN
   logic [31:0] stall_q;

   // Saturating count of cycles where a beat waits on backpressure.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         stall_q <= '0;
      end else if (cmd_accept) begin
         stall_q <= '0;
      end else if (o_data_valid && !i_data_ready && (stall_q != '1)) begin
         stall_q <= stall_q + 32'd1;
      end
   end

   assign o_stall_cycles = stall_q;
`else
   assign o_stall_cycles = '0;
`endif

   assign o_buf_addr    = issue ? issue_addr : addr_hold_q;
   assign o_buf_read    = 1'b1;
   assign o_buf_write   = 1'b0;
   assign o_buf_size    = BUF_NO_WRITE_SIZE;
   assign o_buf_wr_data = '0;
   assign o_cmd_ready   = (state_q == StIdle);
   assign o_busy        = (state_q != StIdle);
   assign o_done        = (state_q == StDone);
   assign o_data_valid  = (fifo_count != '0);
   assign o_data        = fifo_head.data;
   assign o_data_last   = fifo_head.last;

endmodule

// File: doc/pim_buf_streamer.md
# pim_buf_streamer

Read-side sequencer placed directly downstream of `pim_buffer`. It accepts a (base address, word count) command, walks the buffer SRAM one 32-bit word per cycle, absorbs the one-cycle SRAM read latency in a small FIFO, and presents the words to the PIM compute array on a valid/ready stream with a last flag. It owns the buffer port in read-only mode and never issues a write.

## Interface
Parameters:
- `MEM_ADDR_WIDTH`, 15: byte-address bits decoded by the buffer; the word index is `[MEM_ADDR_WIDTH-1:2]`.
- `LEN_WIDTH`, 16: width of the word-count field.
- `FIFO_DEPTH`, 4: return-FIFO entries. Minimum 3 for 1 word/cycle.

Ports:
- `i_clk`  in  1  clock; all logic is on the rising edge.
- `i_rst`  in  1  asynchronous, active-high reset.
- `i_cmd_valid`  in  1  command request.
- `o_cmd_ready`  out  1  high only in IDLE.
- `i_cmd_base_addr`  in  32  byte address of the first word; bits [1:0] are ignored.
- `i_cmd_len`  in  LEN_WIDTH  number of words to stream.
- `o_buf_addr`  out  32  to `pim_buffer` `i_buf_addr`.
- `o_buf_read`  out  1  to `i_buf_read`; constant 1, including during reset (GWEN high, no write).
- `o_buf_write`  out  1  constant 0.
- `o_buf_size`  out  4  constant 4'b1111 (all byte write-enables inactive).
- `o_buf_wr_data`  out  32  constant 0.
- `i_buf_rd_data`  in  32  SRAM Q; valid one cycle after the address is presented.
- `o_data_valid`, `o_data`[31:0], `o_data_last`  out  stream to the PIM array.
- `i_data_ready`  in  1  stream backpressure.
- `o_busy`  out  1  high when the state is not IDLE.
- `o_done`  out  1  one-cycle pulse at command completion.
- `o_stall_cycles`  out  32  performance counter (see Configuration).

## Operation
- FSM states:
  - IDLE → STREAM on `i_cmd_valid && o_cmd_ready` with len≠0. Latch the base word index and set `remaining` = len.
  - IDLE → DONE on an accepted command with len=0. No beats are produced.
  - STREAM → DRAIN when the last read issues.
  - DRAIN → DONE when the FIFO is empty and no read is in flight.
  - DONE → IDLE unconditionally. `o_done`=1 for exactly the DONE cycle.
- Issue rule in STREAM: issue when `fifo_count + inflight < FIFO_DEPTH`.
  - An issue drives `o_buf_addr`, sets `inflight` for the next cycle, decrements `remaining`, and increments the word index.
  - The next cycle writes `i_buf_rd_data` into the FIFO.
- Address arithmetic:
  - Word index is `MEM_ADDR_WIDTH-2` bits and wraps modulo 2^(MEM_ADDR_WIDTH-2).
  - `o_buf_addr` = {zeros, index, 2'b00`}`. Upper base bits are discarded.
  - `o_buf_addr` holds its last value when not issuing.
- Stream side:
  - `o_data_valid` = FIFO non-empty; `o_data` = FIFO head.
  - Pop on `o_data_valid && i_data_ready`.
  - `o_data_last` is high on the head entry that is the final word of the command. Store a last bit per entry.
  - Once valid, `o_data` and `o_data_last` are stable until the beat is accepted.
- A push and a pop in the same cycle are both honoured; the count is unchanged.
- A command presented while busy is ignored (`o_cmd_ready`=0). Nothing is queued.
- Reset mid-operation:
  - Returns to IDLE, empties the FIFO, clears `inflight`, and discards the in-flight SRAM word.
  - No `o_done` pulse, no partial `o_data_last`.

## Timing
- Reset values: `o_cmd_ready`=1, `o_data_valid`=0, `o_data_last`=0, `o_data`=0, `o_busy`=0, `o_done`=0, `o_buf_addr`=0, `o_stall_cycles`=0. Constant outputs as listed in Interface.
- With the command accepted at the edge ending cycle T:
  - First read issues in T+1.
  - Data is captured at the end of T+2.
  - First `o_data_valid` is in T+3.
- With ready held high, throughput is 1 word/cycle (FIFO_DEPTH ≥ 3).
- The last beat is accepted in cycle L; `o_done` pulses in L+1; `o_cmd_ready` returns in L+2.
- len=0: `o_done` pulses in T+1.

## Configuration
- `PIM_STREAMER_PERF_EN` defined:
  - `o_stall_cycles` increments every cycle with `o_data_valid && !i_data_ready`.
  - It clears on command acceptance and saturates at 2^32-1.
- Undefined: no counter is built; `o_stall_cycles` is tied to 0.

## Structure
- Shared package `pim_pkg` holds:
  - the state enum (IDLE, STREAM, DRAIN, DONE);
  - `WORD_BYTES`=4;
  - `BUF_NO_WRITE_SIZE`=4'b1111.
- Sub-module `pim_stream_fifo`: synchronous FIFO of {last, data[31:0]}, depth `FIFO_DEPTH`. It has push/pop/count ports, and the output is the registered head.

## Test plan
1. Base 0x100, len 4, ready high:
   - `o_buf_addr` 0x100, 0x104, 0x108, 0x10C on consecutive cycles.
   - Four beats, first in T+3, `o_data_last` on beat 4 only, `o_done` one cycle after beat 4.
2. Ready low for 10 cycles mid-stream of len 8:
   - At most `FIFO_DEPTH` words are fetched ahead.
   - No beat is lost or duplicated; data matches memory order.
   - `o_stall_cycles`=10 with the macro, 0 without.
3. Base 0x7FFC, len 3, MEM_ADDR_WIDTH=15: addresses 0x7FFC, 0x0000, 0x0004.
4. len 0: `o_done` in T+1, `o_data_valid` never asserts.
5. Second `i_cmd_valid` held during a busy stream: ignored. It is accepted in the first IDLE cycle after `o_done`.
6. `i_rst` asserted with 2 words in the FIFO and 1 in flight:
   - Outputs take reset values asynchronously.
   - After release, no stale beat appears and a new command streams correctly.
